// File: rtl/swt16_pkg.sv
// Shared swt16 definitions: DMEM arbiter state encoding and default bus widths.
package swt16_pkg;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_EXT  = 1'b1
    } arb_state_t;

    localparam int DMEM_ADDR_WIDTH_DEF = 12;
    localparam int DMEM_WORD_WIDTH_DEF = 16;
    localparam int MAX_WAIT_DEF        = 4;
    localparam int EXT_BURST_DEF       = 2;
    localparam int WAIT_WIDTH_DEF      = 3;

endpackage

// File: rtl/dmem_arb.sv
// Data-memory arbiter: the core's MEM stage has priority, and a starved external
// port (loader/debug) is given a bounded burst of forced grants.
module dmem_arb
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
    parameter int MAX_WAIT        = MAX_WAIT_DEF,
    parameter int EXT_BURST       = EXT_BURST_DEF,
    parameter int WAIT_WIDTH      = WAIT_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       core_rd_en,
    input  logic                       core_wr_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] core_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] core_wr_word,
    output logic                       core_stall,
    input  logic                       ext_req,
    input  logic                       ext_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] ext_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] ext_wdata,
    output logic                       ext_gnt,
    output logic                       ext_rvalid,
    output logic [DMEM_WORD_WIDTH-1:0] ext_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] mem_wr_word,
    output logic                       mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] mem_rd_word
);

    localparam int BURST_WIDTH = $clog2(EXT_BURST + 1);
    localparam logic [WAIT_WIDTH-1:0]  WAIT_MAX  = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(EXT_BURST);

    arb_state_t              state_q, state_d;
    logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
    logic [BURST_WIDTH-1:0]  burst_q, burst_d;
    logic [BURST_WIDTH-1:0]  burst_inc;
    logic                    core_active;
    logic                    core_served;
    logic                    rd_vld_p1;

    assign core_active = core_rd_en | core_wr_en;
    assign burst_inc   = burst_q + 1'b1;
    // Grants are gated by reset so every output is quiet while it is held.
    assign core_served = reset & core_active & ~ext_gnt;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        burst_d    = burst_q;
        ext_gnt    = 1'b0;
        core_stall = 1'b0;
        if (reset && ext_req) begin
            case (state_q)
                ARB_CORE: begin
                    if (wait_q >= WAIT_MAX) begin
                        ext_gnt    = 1'b1;
                        core_stall = core_active;
                        wait_d     = '0;
                        burst_d    = BURST_WIDTH'(1);
                        state_d    = (EXT_BURST > 1) ? ARB_EXT : ARB_CORE;
                    end else if (!core_active) begin
                        ext_gnt = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ARB_EXT: begin
                    ext_gnt    = 1'b1;
                    core_stall = core_active;
                    wait_d     = '0;
                    burst_d    = burst_inc;
                    if (burst_inc >= BURST_MAX) begin
                        state_d = ARB_CORE;
                    end
                end
            endcase
        end else begin
            wait_d = '0;
            if (state_q == ARB_EXT) begin
                state_d = ARB_CORE;
            end
        end
    end

    always_comb begin
        mem_rd_addr  = '0;
        mem_wr_addr  = '0;
        mem_wr_word  = '0;
        mem_write_en = 1'b0;
        if (ext_gnt) begin
            mem_rd_addr  = ext_addr;
            mem_wr_addr  = ext_addr;
            mem_wr_word  = ext_wdata;
            mem_write_en = ext_we;
        end else if (core_served) begin
            mem_rd_addr  = core_rd_addr;
            mem_wr_addr  = core_wr_addr;
            mem_wr_word  = core_wr_word;
            mem_write_en = core_wr_en;
        end
    end

    // p0 -> p1: DMEM answers one cycle after the address, so the read-valid follows it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_CORE;
            wait_q    <= '0;
            burst_q   <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            burst_q   <= burst_d;
            rd_vld_p1 <= ext_gnt & ~ext_we;
        end
    end

    assign ext_rvalid = rd_vld_p1;
    assign ext_rdata  = rd_vld_p1 ? mem_rd_word : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: behavioural DMEM, vector table plus multi-cycle arbitration sequences.
module tb_dmem_arb;

    localparam int AW = 12;
    localparam int WW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          core_rd_en = 1'b0;
    logic          core_wr_en = 1'b0;
    logic [AW-1:0] core_rd_addr = '0;
    logic [AW-1:0] core_wr_addr = '0;
    logic [WW-1:0] core_wr_word = '0;
    logic          core_stall;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [WW-1:0] ext_wdata = '0;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [WW-1:0] ext_rdata;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_wr_addr;
    logic [WW-1:0] mem_wr_word;
    logic          mem_write_en;
    logic [WW-1:0] mem_rd_word;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] ref_mem [logic [AW-1:0]];
    logic [WW-1:0] dmem [4096];
    logic [4095:0] wr_mask = '0;

    typedef struct {
        logic          rd, wr;
        logic [AW-1:0] ra, wa;
        logic [WW-1:0] wd;
        logic          er, ewe;
        logic [AW-1:0] ea;
        logic [WW-1:0] ewd;
        logic          gnt, stall;
        logic [AW-1:0] mra, mwa;
        logic [WW-1:0] mwd;
        logic          mwe;
    } vec_t;

    vec_t vecs [11];

    dmem_arb #(
        .DMEM_ADDR_WIDTH(AW),
        .DMEM_WORD_WIDTH(WW),
        .MAX_WAIT(4),
        .EXT_BURST(2),
        .WAIT_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .core_rd_en(core_rd_en),
        .core_wr_en(core_wr_en),
        .core_rd_addr(core_rd_addr),
        .core_wr_addr(core_wr_addr),
        .core_wr_word(core_wr_word),
        .core_stall(core_stall),
        .ext_req(ext_req),
        .ext_we(ext_we),
        .ext_addr(ext_addr),
        .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_word(mem_wr_word),
        .mem_write_en(mem_write_en),
        .mem_rd_word(mem_rd_word)
    );

    always #5 clock = ~clock;

    // Unwritten locations read back a recognisable address-derived pattern.
    function automatic logic [WW-1:0] seed(input logic [AW-1:0] a);
        return {4'hC, a};
    endfunction

    function automatic logic [WW-1:0] exp_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed(a);
    endfunction

    always @(posedge clock) begin
        if (mem_write_en) begin
            dmem[mem_wr_addr]    <= mem_wr_word;
            wr_mask[mem_wr_addr] <= 1'b1;
        end
        mem_rd_word <= wr_mask[mem_rd_addr] ? dmem[mem_rd_addr] : seed(mem_rd_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [WW-1:0] e;
        if (ext_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(ext_rvalid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ext_rdata", 32'(ext_rdata), 32'(e));
            end
        end else begin
            chk("rdata_idle_zero", 32'(ext_rdata), 32'd0);
        end
    end

    task automatic tick_in();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        core_rd_en   = 1'b0;
        core_wr_en   = 1'b0;
        core_rd_addr = '0;
        core_wr_addr = '0;
        core_wr_word = '0;
        ext_req      = 1'b0;
        ext_we       = 1'b0;
        ext_addr     = '0;
        ext_wdata    = '0;
    endtask

    task automatic idle_cycle();
        idle_in();
        @(negedge clock);
        tick_in();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},   32'(ext_gnt),      32'd0);
        chk({tag, "_stall"}, 32'(core_stall),   32'd0);
        chk({tag, "_rvld"},  32'(ext_rvalid),   32'd0);
        chk({tag, "_rdata"}, 32'(ext_rdata),    32'd0);
        chk({tag, "_we"},    32'(mem_write_en), 32'd0);
        chk({tag, "_ra"},    32'(mem_rd_addr),  32'd0);
        chk({tag, "_wa"},    32'(mem_wr_addr),  32'd0);
        chk({tag, "_wd"},    32'(mem_wr_word),  32'd0);
    endtask

    task automatic run_table();
        for (int r = 0; r < 11; r++) begin
            core_rd_en   = vecs[r].rd;
            core_wr_en   = vecs[r].wr;
            core_rd_addr = vecs[r].ra;
            core_wr_addr = vecs[r].wa;
            core_wr_word = vecs[r].wd;
            ext_req      = vecs[r].er;
            ext_we       = vecs[r].ewe;
            ext_addr     = vecs[r].ea;
            ext_wdata    = vecs[r].ewd;
            @(negedge clock);
            chk($sformatf("vec%0d_gnt", r),   32'(ext_gnt),      32'(vecs[r].gnt));
            chk($sformatf("vec%0d_stall", r), 32'(core_stall),   32'(vecs[r].stall));
            chk($sformatf("vec%0d_ra", r),    32'(mem_rd_addr),  32'(vecs[r].mra));
            chk($sformatf("vec%0d_wa", r),    32'(mem_wr_addr),  32'(vecs[r].mwa));
            chk($sformatf("vec%0d_wd", r),    32'(mem_wr_word),  32'(vecs[r].mwd));
            chk($sformatf("vec%0d_we", r),    32'(mem_write_en), 32'(vecs[r].mwe));
            if (vecs[r].gnt && vecs[r].er && !vecs[r].ewe) exp_q.push_back(exp_rd(vecs[r].ea));
            if (vecs[r].mwe) ref_mem[vecs[r].mwa] = vecs[r].mwd;
            tick_in();
        end
    endtask

    // Core stores every cycle against a held ext read: 4 waits, 2 forced grants, core again.
    task automatic seq_store_burst();
        logic exp_g;
        int   k = 0;
        for (int i = 0; i < 7; i++) begin
            exp_g = (i == 4 || i == 5);
            core_wr_en   = 1'b1;
            core_wr_addr = 12'h300 + 12'(k);
            core_wr_word = 16'h9000 + 16'(k);
            ext_req      = 1'b1;
            ext_we       = 1'b0;
            ext_addr     = 12'h040;
            @(negedge clock);
            chk($sformatf("burst%0d_gnt", i),   32'(ext_gnt),      32'(exp_g));
            chk($sformatf("burst%0d_stall", i), 32'(core_stall),   32'(exp_g));
            chk($sformatf("burst%0d_we", i),    32'(mem_write_en), 32'(!exp_g));
            if (exp_g) begin
                exp_q.push_back(exp_rd(12'h040));
            end else begin
                chk($sformatf("burst%0d_wa", i), 32'(mem_wr_addr), 32'(12'h300 + 12'(k)));
                ref_mem[core_wr_addr] = core_wr_word;
                k++;
            end
            tick_in();
        end
        idle_cycle();
    endtask

    // ext_req dropped during the forced burst: core served at once, arbiter back in ARB_CORE.
    task automatic seq_burst_drop();
        logic exp_g;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i == 4);
            core_rd_en   = 1'b1;
            core_rd_addr = 12'h050;
            ext_req      = (i != 5);
            ext_we       = 1'b0;
            ext_addr     = 12'h060;
            @(negedge clock);
            chk($sformatf("drop%0d_gnt", i),   32'(ext_gnt),    32'(exp_g));
            chk($sformatf("drop%0d_stall", i), 32'(core_stall), 32'(exp_g));
            chk($sformatf("drop%0d_ra", i),    32'(mem_rd_addr), exp_g ? 32'h060 : 32'h050);
            if (exp_g) exp_q.push_back(exp_rd(12'h060));
            tick_in();
        end
        idle_cycle();
    endtask

    // Reset lands before the edge that would raise ext_rvalid for a granted read.
    task automatic seq_reset_inflight();
        ext_req  = 1'b1;
        ext_we   = 1'b0;
        ext_addr = 12'h070;
        @(negedge clock);
        chk("rst_pre_gnt", 32'(ext_gnt), 32'd1);
        #1;
        reset      = 1'b0;
        core_wr_en = 1'b1;
        core_rd_en = 1'b1;
        core_wr_addr = 12'h111;
        core_rd_addr = 12'h222;
        core_wr_word = 16'hDEAD;
        tick_in();
        chk_quiet("rst_hold");
        @(negedge clock);
        #1;
        idle_in();
        reset = 1'b1;
        tick_in();
        @(negedge clock);
        chk("rst_post_rvld", 32'(ext_rvalid), 32'd0);
        tick_in();
    endtask

    // Busy core alternating store/load while four ext writes are pushed through forced grants.
    task automatic seq_ext_writes();
        logic exp_g;
        int   n = 0;
        int   j = 0;
        for (int i = 0; i < 12; i++) begin
            exp_g = (i == 4 || i == 5 || i == 10 || i == 11);
            ext_req      = 1'b1;
            ext_we       = 1'b1;
            ext_addr     = 12'h020 + 12'(n);
            ext_wdata    = 16'(n + 1);
            core_wr_en   = (j % 2 == 0);
            core_rd_en   = (j % 2 == 1);
            core_wr_addr = 12'h400 + 12'(j);
            core_wr_word = 16'h6000 + 16'(j);
            core_rd_addr = 12'h410;
            @(negedge clock);
            chk($sformatf("xw%0d_gnt", i),   32'(ext_gnt),    32'(exp_g));
            chk($sformatf("xw%0d_stall", i), 32'(core_stall), 32'(exp_g));
            if (exp_g) begin
                ref_mem[ext_addr] = ext_wdata;
                n++;
            end else begin
                if (core_wr_en) ref_mem[core_wr_addr] = core_wr_word;
                j++;
            end
            tick_in();
        end
        idle_cycle();
    endtask

    // Back-to-back ext reads of everything written so far; each returns in order.
    task automatic seq_readback();
        logic [AW-1:0] rb [13];
        for (int i = 0; i < 4; i++) rb[i] = 12'h020 + 12'(i);
        for (int i = 0; i < 5; i++) rb[4 + i] = 12'h300 + 12'(i);
        for (int i = 0; i < 4; i++) rb[9 + i] = 12'h400 + 12'(2 * i);
        for (int i = 0; i < 13; i++) begin
            ext_req  = 1'b1;
            ext_we   = 1'b0;
            ext_addr = rb[i];
            @(negedge clock);
            chk($sformatf("rb%0d_gnt", i),  32'(ext_gnt),    32'd1);
            chk($sformatf("rb%0d_rvld", i), 32'(ext_rvalid), 32'(i > 0));
            exp_q.push_back(exp_rd(rb[i]));
            tick_in();
        end
        idle_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 12'h100, 12'h200, 16'hBEEF, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h100, 12'h200, 16'hBEEF, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 12'h101, 12'h055, 16'h1111, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h101, 12'h055, 16'h1111, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h010, 16'h7777,
                     1'b1, 1'b0, 12'h010, 12'h010, 16'h7777, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h030, 16'hA5A5,
                     1'b1, 1'b0, 12'h030, 12'h030, 16'hA5A5, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 12'h000, 12'h031, 16'h5A5A, 1'b1, 1'b0, 12'h030, 16'h0000,
                     1'b0, 1'b0, 12'h000, 12'h031, 16'h5A5A, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 12'h031, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h031, 12'h000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h031, 16'h0000,
                     1'b1, 1'b0, 12'h031, 12'h031, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h030, 16'h0000,
                     1'b1, 1'b0, 12'h030, 12'h030, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0};

        repeat (2) @(negedge clock);
        chk_quiet("reset");
        #2;
        reset = 1'b1;
        tick_in();

        run_table();
        seq_store_burst();
        seq_burst_drop();
        seq_reset_inflight();
        seq_ext_writes();
        seq_readback();

        repeat (2) idle_cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- DMEM_ADDR_WIDTH, 12, DMEM address width.
- DMEM_WORD_WIDTH, 16, DMEM word width.
- MAX_WAIT, 4, ext wait cycles before a forced grant (>=1).
- EXT_BURST, 2, max consecutive forced ext grants (>=1).
- WAIT_WIDTH, 3, width of the wait counter (holds MAX_WAIT).
REQ-002 Ports SHALL be as listed: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_rd_en  in  1  MEM-stage load request.
- core_wr_en  in  1  MEM-stage store request.
- core_rd_addr  in  DMEM_ADDR_WIDTH  load address.
- core_wr_addr  in  DMEM_ADDR_WIDTH  store address.
- core_wr_word  in  DMEM_WORD_WIDTH  store data.
- core_stall  out  1  core request not served this cycle; core holds it.
- ext_req  in  1  loader/debug access request.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  DMEM_ADDR_WIDTH  ext address.
- ext_wdata  in  DMEM_WORD_WIDTH  ext write data.
- ext_gnt  out  1  ext access performed this cycle (combinational).
- ext_rvalid  out  1  ext read data valid.
- ext_rdata  out  DMEM_WORD_WIDTH  ext read data.
- mem_rd_addr  out  DMEM_ADDR_WIDTH  to DMEM.
- mem_wr_addr  out  DMEM_ADDR_WIDTH  to DMEM.
- mem_wr_word  out  DMEM_WORD_WIDTH  to DMEM.
- mem_write_en  out  1  to DMEM.
- mem_rd_word  in  DMEM_WORD_WIDTH  from DMEM; valid one cycle after the address.

Function
REQ-003 core_active SHALL be core_rd_en OR core_wr_en; a core read and write in the same cycle SHALL both be served, using separate read and write addresses.
REQ-004 FSM states SHALL be ARB_CORE (reset state) and ARB_EXT.
REQ-005 In ARB_CORE with ext_req=1 and core_active=0, ext_gnt SHALL be 1, with no state change.
REQ-006 In ARB_CORE with ext_req=1, core_active=1 and wait_cnt<MAX_WAIT, the core SHALL be served, ext_gnt SHALL be 0, and wait_cnt SHALL increment, saturating at MAX_WAIT.
REQ-007 In ARB_CORE with ext_req=1 and wait_cnt==MAX_WAIT, the block SHALL apply a forced grant:
- ext_gnt=1 and core_stall=core_active;
- burst_cnt=1;
- next state ARB_EXT if EXT_BURST>1, else ARB_CORE.
REQ-008 In ARB_EXT with ext_req=1, the block SHALL set ext_gnt=1 and core_stall=core_active, and increment burst_cnt; when burst_cnt reaches EXT_BURST, next state SHALL be ARB_CORE.
REQ-009 In ARB_EXT with ext_req=0, the core SHALL be served that cycle with core_stall=0, and next state SHALL be ARB_CORE.
REQ-010 Every ext_gnt SHALL clear wait_cnt to 0; ext_req=0 SHALL also clear wait_cnt.
REQ-011 core_stall SHALL be 0 whenever ext_gnt=0.
REQ-012 DMEM mux when the core is served: mem_rd_addr=core_rd_addr, mem_wr_addr=core_wr_addr, mem_wr_word=core_wr_word, mem_write_en=core_wr_en.
REQ-013 DMEM mux when ext is granted: both addresses = ext_addr, mem_wr_word=ext_wdata, mem_write_en=ext_we.
REQ-014 When there is no access, all mem_* outputs SHALL be 0.
REQ-015 On an ext read grant, ext_rvalid SHALL be registered to 1 in the next cycle, with ext_rdata=mem_rd_word in that cycle.
- ext_rdata SHALL be 0 when ext_rvalid=0.
- A stalled core load SHALL NOT have its data returned.
REQ-016 Back-to-back ext reads SHALL produce back-to-back ext_rvalid pulses in order.

Reset
REQ-017 reset=0 SHALL asynchronously force: state ARB_CORE, wait_cnt=0, burst_cnt=0, ext_rvalid=0.
- Outputs then become: ext_gnt=0, core_stall=0, ext_rdata=0, mem_*=0.
REQ-018 Reset asserted mid-burst or with a read in flight SHALL drop the pending ext_rvalid with no later pulse.

Structure
REQ-019 The arb_state_t encoding (ARB_CORE=0, ARB_EXT=1) and default widths SHALL live in the shared swt16 package.
REQ-020 dmem_arb SHALL be a single module with no sub-modules.

Verification
REQ-021 Use MAX_WAIT=4, EXT_BURST=2 for all scenarios:
- Idle core, ext read 0x010 -> ext_gnt same cycle; next cycle ext_rvalid=1, ext_rdata=DMEM[0x010].
- Core store every cycle, ext_req held -> 4 cycles with ext_gnt=0; cycles 5-6 ext_gnt=1 and core_stall=1; cycle 7 core served; no lost store.
- Forced burst, ext_req dropped after the 1st forced grant -> return to ARB_CORE, core_stall=0 the next cycle.
- Core load and store to different addresses in one cycle, no ext -> both served; mem_write_en=1; core_stall=0.
- Reset pulsed the cycle after an ext read grant -> no ext_rvalid; all outputs 0.
- Alternating ext writes 0x1..0x4 under a busy core, then ext readback -> DMEM contents match.
